// File: rtl/rr_packet_arbiter_if.sv
// Bundle of the N request streams, the shared output stream and grant status for rr_packet_arbiter.
// The master side is the arbiter; the slave side is the surrounding system (sources plus sink).
interface rr_packet_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int SW = $clog2(N);

  logic [N-1:0]          en;
  logic [N-1:0]          in_valid;
  logic [N-1:0][DW-1:0]  in_data;   // requester i occupies bits [i*DW +: DW]
  logic [N-1:0]          in_last;
  logic [N-1:0]          in_ready;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [N-1:0]          grant;
  logic [SW-1:0]         grant_idx;
  logic                  busy;

  modport master (
    input  en, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant, grant_idx, busy
  );

  modport slave (
    output en, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant, grant_idx, busy
  );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Packet-level round-robin arbiter: one owner holds the output until its last beat is accepted,
// then priority rotates to the requester after it.

module rr_lane #(
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          vld_m,
  output logic          last_m,
  output logic [DW-1:0] data_m
);
  // Unselected lanes contribute zeros so the output is a plain OR across lanes.
  assign in_ready = sel & out_ready;
  assign vld_m    = sel & in_valid;
  assign last_m   = sel & in_last;
  assign data_m   = in_data & {DW{sel}};
endmodule

module rr_packet_arbiter #(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int SW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_packet_arbiter_if.master  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [N-1:0]         grant_q, grant_nxt;
  logic [SW-1:0]        idx_q, idx_nxt;
  logic [SW-1:0]        ptr_q, ptr_nxt;

  logic [N-1:0]         cand;
  logic                 pick_ok;
  logic [SW-1:0]        pick;
  logic [SW-1:0]        idx;

  logic [N-1:0]         vld_m, last_m;
  logic [N-1:0][DW-1:0] data_m;
  logic                 out_valid_c, out_last_c;
  logic [DW-1:0]        out_data_c;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      rr_lane #(.DW(DW)) u_lane (
        .sel       (grant_q[gi]),
        .in_valid  (bus.in_valid[gi]),
        .in_last   (bus.in_last[gi]),
        .in_data   (bus.in_data[gi]),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready[gi]),
        .vld_m     (vld_m[gi]),
        .last_m    (last_m[gi]),
        .data_m    (data_m[gi])
      );
    end
  endgenerate

  always_comb begin
    out_data_c = '0;
    for (int i = 0; i < N; i++) out_data_c = out_data_c | data_m[i];
  end

  assign out_valid_c   = |vld_m;
  assign out_last_c    = |last_m;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_c;
  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = (state == BUSY);

  // First enabled requester at or after ptr, wrapping modulo N (N need not be a power of two).
  always_comb begin
    cand    = bus.in_valid & bus.en;
    pick_ok = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(ptr_q) + k) % N);
      if (!pick_ok && cand[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = BUSY;
          grant_nxt = N'(1) << pick;
          idx_nxt   = pick;
        end
      end
      BUSY: begin
        if (out_valid_c && bus.out_ready && out_last_c) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
          ptr_nxt   = (idx_q == SW'(N - 1)) ? '0 : idx_q + SW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      idx_q   <= idx_nxt;
      ptr_q   <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Random and directed stimulus for rr_packet_arbiter, checked every cycle against an owner/pointer model
// and a per-source sink scoreboard that catches lost, duplicated or interleaved beats.
module tb_rr_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rr_packet_arbiter_if #(.N(N), .DW(DW)) bus ();
  rr_packet_arbiter #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  // Reference model: who owns the output (-1 = idle), rotation pointer, grant history.
  int owner = -1;
  int ptr   = 0;
  int glog[$];

  // Sources and sink scoreboard.
  int src_len[N], src_beat[N], src_pkt[N], fix_len[N];
  bit req[N], one_shot[N], vgate[N];
  int sink_beat[N], sink_pkt[N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_word(input int s, input int p, input int b);
    return {8'(s), 8'(p), 16'(b)};
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i] = (req[i] || src_beat[i] != 0) && vgate[i];
      bus.in_last[i]  = (src_beat[i] == src_len[i] - 1);
      bus.in_data[i]  = beat_word(i, src_pkt[i], src_beat[i]);
    end
  endtask

  task automatic adv_src(input int i);
    if (src_beat[i] == src_len[i] - 1) begin
      src_beat[i] = 0;
      src_pkt[i]++;
      src_len[i] = (fix_len[i] != 0) ? fix_len[i] : int'($urandom_range(1, 4));
      if (one_shot[i]) req[i] = 1'b0;
    end else begin
      src_beat[i]++;
    end
  endtask

  task automatic cfg_len(input int i, input int l);
    fix_len[i] = l;
    if (src_beat[i] == 0) src_len[i] = l;
  endtask

  // One clock: drive at negedge, compare combinational outputs, advance model at posedge.
  task automatic step();
    logic [N-1:0]  exp_g, exp_r;
    logic [DW-1:0] exp_d;
    logic          ev, el, xfer, xlast, found;
    int            o, w;
    apply();
    #1;
    o     = owner;
    exp_g = (o < 0) ? '0 : (N'(1) << o);
    ev    = (o >= 0) ? bus.in_valid[o] : 1'b0;
    el    = (o >= 0) ? bus.in_last[o]  : 1'b0;
    exp_d = (o >= 0) ? bus.in_data[o]  : '0;
    exp_r = (o >= 0 && bus.out_ready) ? exp_g : '0;
    chk("grant",     bus.grant,     exp_g);
    chk("grant_idx", bus.grant_idx, (o < 0) ? 0 : o);
    chk("busy",      bus.busy,      o >= 0);
    chk("out_valid", bus.out_valid, ev);
    chk("out_last",  bus.out_last,  el);
    chk("out_data",  bus.out_data,  exp_d);
    chk("in_ready",  bus.in_ready,  exp_r);
    xfer  = ev & bus.out_ready;
    xlast = xfer & el;
    if (xfer) begin
      chk("sink_seq", bus.out_data, beat_word(o, sink_pkt[o], sink_beat[o]));
      if (el) begin sink_pkt[o]++; sink_beat[o] = 0; end
      else sink_beat[o]++;
      adv_src(o);
    end
    @(posedge clk);
    if (rst) begin
      owner = -1;
      ptr   = 0;
    end else if (o < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        w = (ptr + k) % N;
        if (!found && bus.in_valid[w] && bus.en[w]) begin
          found = 1'b1;
          owner = w;
          glog.push_back(w);
        end
      end
    end else if (xlast) begin
      ptr   = (o + 1) % N;
      owner = -1;
    end
    @(negedge clk);
  endtask

  function automatic bit pending();
    bit p = (owner >= 0);
    for (int i = 0; i < N; i++) p = p | req[i] | (src_beat[i] != 0);
    return p;
  endfunction

  task automatic drain(input int limit, input string tag);
    int n = 0;
    bus.en        = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin one_shot[i] = 1'b1; vgate[i] = 1'b1; end
    while (pending() && n < limit) begin step(); n++; end
    chk({tag, "_drain"}, pending(), 1'b0);
  endtask

  // Reset for one cycle; any packet in flight is abandoned at both ends.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_beat[i] != 0) begin src_pkt[i]++; src_beat[i] = 0; end
      sink_pkt[i]  = src_pkt[i];
      sink_beat[i] = 0;
    end
    glog.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt, mark, p1, n;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_beat[i] = 0; src_pkt[i] = 0; fix_len[i] = 0;
      req[i] = 0; one_shot[i] = 0; vgate[i] = 1;
      sink_beat[i] = 0; sink_pkt[i] = 0;
    end
    bus.en = 4'b1111;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", bus.grant, 0);
    chk("rst_idx",   bus.grant_idx, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 0);

    // Single requester, 3-beat packet.
    req[2] = 1; one_shot[2] = 1; cfg_len(2, 3);
    step();
    chk("t1_grant", bus.grant, 4'b0100);
    drain(10, "t1");
    chk("t1_busy", bus.busy, 0);
    chk("t1_pkts", sink_pkt[2], 1);
    chk("t1_nlog", glog.size(), 1);
    chk("t1_who",  glog[0], 2);

    // All requesting, 2-beat packets: rotation and 3 cycles per packet.
    do_reset();
    base = 0;
    for (int i = 0; i < N; i++) begin req[i] = 1; one_shot[i] = 0; cfg_len(i, 2); base += sink_pkt[i]; end
    repeat (12) step();
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += sink_pkt[i];
    chk("t2_pkts", cnt - base, 4);
    chk("t2_nlog", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("t2_order", glog[k], k);
    drain(40, "t2");

    // Wrap: serve 2, then 1 and 3 together -> 3 then 1, then pointer sits at 2.
    glog.delete();
    req[2] = 1; drain(20, "t3a");
    req[1] = 1; req[3] = 1; drain(20, "t3b");
    for (int i = 0; i < N; i++) req[i] = 1;
    drain(40, "t3c");
    chk("t3_nlog", glog.size(), 7);
    if (glog.size() >= 4) begin
      chk("t3_g0", glog[0], 2);
      chk("t3_g1", glog[1], 3);
      chk("t3_g2", glog[2], 1);
      chk("t3_g3", glog[3], 2);
    end

    // Backpressure and owner gaps with a competing requester.
    do_reset();
    req[0] = 1; cfg_len(0, 1); drain(10, "t4a");
    glog.delete();
    p1 = sink_pkt[1]; base = sink_pkt[0];
    req[0] = 1; cfg_len(0, 2); req[1] = 1; cfg_len(1, 4);
    one_shot[0] = 1; one_shot[1] = 1;
    n = 0;
    while (pending() && n < 60) begin
      bus.out_ready = (n % 2 == 1);
      vgate[1] = !(n == 3 || n == 4);
      step();
      n++;
    end
    chk("t4_done", pending(), 0);
    bus.out_ready = 1'b1; vgate[1] = 1;
    chk("t4_nlog", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t4_first",  glog[0], 1);
      chk("t4_second", glog[1], 0);
    end
    chk("t4_pkt1", sink_pkt[1] - p1, 1);
    chk("t4_pkt0", sink_pkt[0] - base, 1);

    // Enable mask; dropping en of the owner mid-packet.
    glog.delete();
    bus.en = 4'b1011;
    for (int i = 0; i < N; i++) begin req[i] = 1; one_shot[i] = 0; fix_len[i] = 0; end
    repeat (40) step();
    cnt = 0;
    foreach (glog[k]) if (glog[k] == 2) cnt++;
    chk("t5_no2", cnt, 0);
    n = 0;
    while (owner != 1 && n < 40) begin step(); n++; end
    chk("t5_own1", owner, 1);
    bus.en = 4'b1001;
    p1 = sink_pkt[1]; mark = glog.size();
    repeat (40) step();
    chk("t5_fin1", sink_pkt[1] > p1, 1);
    cnt = 0;
    for (int k = mark; k < glog.size(); k++) if (glog[k] == 1 || glog[k] == 2) cnt++;
    chk("t5_no1", cnt, 0);
    drain(200, "t5");

    // Reset on beat 2 of a 4-beat packet.
    do_reset();
    req[3] = 1; one_shot[3] = 1; cfg_len(3, 4);
    step();
    step();
    chk("t6_beat", src_beat[3], 1);
    do_reset();
    chk("t6_grant", bus.grant, 0);
    chk("t6_busy",  bus.busy, 0);
    chk("t6_valid", bus.out_valid, 0);
    for (int i = 0; i < N; i++) req[i] = 1;
    drain(60, "t6");
    chk("t6_first", (glog.size() > 0) ? glog[0] : -1, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.en[i] = ($urandom % 8) != 0;
        vgate[i]  = ($urandom % 4) != 0;
        req[i]    = ($urandom % 3) != 0;
        one_shot[i] = 0;
        fix_len[i]  = 0;
      end
      bus.out_ready = ($urandom % 4) != 0;
      if ($urandom % 200 == 0) do_reset();
      else step();
    end
    drain(300, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_packet_arbiter.md
# rr_packet_arbiter

Packet-level round-robin arbiter that shares one valid/ready output stream among N input streams. A requester, once granted, owns the output until its packet completes (beat with `last` accepted); priority then rotates to the requester after the one just served. It sits in front of any shared single-port sink (FIFO, bus master, serializer) that must never see interleaved packets.

## Interface
- `N`, 4, number of requesters (N >= 2)
- `DW`, 32, data width per beat
- `SW`, $clog2(N), width of the select index (derived, not overridden)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  N  per-requester enable; a disabled requester is never newly granted
- `in_valid`  in  N  beat valid per requester
- `in_data`  in  N*DW  beat data, requester i at bits [i*DW +: DW]
- `in_last`  in  N  last beat of packet per requester
- `in_ready`  out  N  beat accepted from requester i when `in_valid[i] & in_ready[i]`
- `out_valid`  out  1  output beat valid
- `out_data`  out  DW  output beat data
- `out_last`  out  1  output last beat
- `out_ready`  in  1  sink accepts beat
- `grant`  out  N  one-hot owner of the output, 0 when idle
- `grant_idx`  out  SW  binary index of owner, 0 when idle
- `busy`  out  1  high while a packet is in progress

## Operation
- State machine, two states: IDLE, BUSY.
- Registered state: `state`, `grant` (one-hot), `grant_idx`, `ptr` (SW bits, highest-priority requester).
- IDLE: candidates = `in_valid & en`. If nonzero, pick the first candidate searching `ptr`, `ptr+1`, … wrapping modulo N; load `grant`/`grant_idx` and go to BUSY. If zero, stay IDLE. No beat is transferred in IDLE.
- BUSY: output is a combinational mux of the granted port: `out_valid = in_valid[g]`, `out_data`, `out_last` likewise; `in_ready[g] = out_ready`; all other `in_ready` bits 0.
- Beat transfer = `out_valid & out_ready`. On a transfer with `out_last`=1: go to IDLE, clear `grant`/`grant_idx`, set `ptr = (g+1) mod N`.
- `en` is sampled only at arbitration; deasserting `en[g]` mid-packet does not abort the packet.
- Owner dropping `in_valid` mid-packet holds the grant (gaps allowed); no timeout.
- Single-beat packets (`in_last` on the first beat) are legal.
- `busy` = (state == BUSY).
- In IDLE: `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=0.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant`=0, `grant_idx`=0, `busy`=0, `out_valid`=0, `in_ready`=0.
- Reset mid-packet: packet is abandoned; the next cycle is IDLE with `ptr`=0. Upstream/downstream cleanup is the system's responsibility.
- Arbitration latency: request seen in IDLE cycle t → grant registered at edge end of t → first beat may transfer in cycle t+1.
- After the last beat transfers in cycle t, cycle t+1 is IDLE (one bubble). The next grant is visible in t+2. Maximum throughput for back-to-back packets is therefore L/(L+1) for length-L packets.
- No combinational path from `out_ready` to `out_valid`. A path `out_ready` → `in_ready` exists by design.
- Fairness: with all N continuously requesting, each requester is served exactly once per N packets.

## Test plan
- Reset then single requester: `en`=4'b1111, requester 2 sends a 3-beat packet with `out_ready`=1 → `grant`=4'b0100 one cycle after `in_valid[2]`; 3 beats appear in order; `out_last` on beat 3; IDLE the next cycle; `ptr`=3.
- All four request continuously with 2-beat packets, `out_ready`=1 → grant order 0,1,2,3,0,…; each packet occupies 3 cycles (2 beats + 1 IDLE).
- Wrap: `ptr`=3 after serving 2; requests from 1 and 3 → 3 granted first, then 1; `ptr` ends at 2.
- Backpressure and gaps: owner 1 sends 4 beats while `out_ready` toggles 1,0,1,0 and `in_valid[1]` drops for 2 cycles mid-packet; requester 0 requests throughout → no beat from 0 until 1's last beat transfers; no beat lost or duplicated; `in_ready[0]`=0 throughout.
- Enable mask: `en`=4'b1011 with all valid → requester 2 is never granted. Clearing `en[1]` during 1's packet → that packet completes, and 1 is not granted afterward.
- Reset mid-packet: assert `rst` on beat 2 of 4 from requester 3 → next cycle `grant`=0, `busy`=0, `out_valid`=0; with all requesting after reset, requester 0 is granted first.
